// File: rtl/ic74x163_counter_n.sv
// ----------------------------------------------------------------------------
// ic74x163_counter_n
//
// A 74163-class synchronous presettable binary counter with configurable
// width, modulus and count direction. It can be cascaded through the
// ripple-carry output, as on the real part.
//
// Parameters
//   WIDTH : counter width in bits (1..16)
//   MAX   : terminal count, 1 <= MAX <= 2^WIDTH-1; the modulus is MAX+1
//
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous clear, active-high (highest priority)
//   load  in   1      synchronous parallel load, active-high
//   enp   in   1      count enable P (does not gate rco)
//   ent   in   1      count enable T (also gates rco)
//   up_dn in   1      1 = count up, 0 = count down
//   d     in   WIDTH  parallel load data
//   q     out  WIDTH  counter state
//   rco   out  1      ripple carry/borrow, combinational from q, ent, up_dn
// ----------------------------------------------------------------------------
module ic74x163_counter_n #(
    parameter int          WIDTH = 4,
    parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enp,
    input  logic             ent,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rco
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    logic             at_top;
    logic             at_zero;
    logic             count_en;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] dn_next;
    logic [WIDTH-1:0] step_next;

    // ">=" rather than "==" so an out-of-range loaded value (d > MAX)
    // is treated as terminal: it raises rco and wraps to zero on the
    // next up-count.
    assign at_top  = (cnt_q >= MAX_V);
    assign at_zero = (cnt_q == ZERO_V);

    assign count_en = enp & ent;

    assign up_next   = at_top  ? ZERO_V : (cnt_q + ONE_V);
    assign dn_next   = at_zero ? MAX_V  : (cnt_q - ONE_V);
    assign step_next = up_dn ? up_next : dn_next;

    // The conditional operators propagate an unknown select to unknown
    // result bits in 4-state simulation. An X/Z on load, the enables or
    // the direction therefore drives q to X instead of being masked.
    assign cnt_d = load     ? d
                 : count_en ? step_next
                 :            cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= ZERO_V;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

    // Gated by ent only, so a cascade of stages can all share enp.
    assign rco = ent & (up_dn ? at_top : at_zero);

endmodule

// File: tb/tb_ic74x163_counter_n.sv
module tb_ic74x163_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the MAX=15 and MAX=9 instances
    logic       rst = 1'b0, load = 1'b0, enp = 1'b0, ent = 1'b0, up_dn = 1'b1;
    logic [3:0] d = 4'd0;
    logic [3:0] q15, q9;
    logic       rco15, rco9;

    // Two-stage cascade
    logic       rst_c = 1'b1, enp_c = 1'b0;
    logic [3:0] q_lo, q_hi, d_c;
    logic       rco_lo, rco_hi;
    assign d_c = 4'd0;

    ic74x163_counter_n #(.WIDTH(4), .MAX(15)) dut15 (
        .clk(clk), .rst(rst), .load(load), .enp(enp), .ent(ent),
        .up_dn(up_dn), .d(d), .q(q15), .rco(rco15));

    ic74x163_counter_n #(.WIDTH(4), .MAX(9)) dut9 (
        .clk(clk), .rst(rst), .load(load), .enp(enp), .ent(ent),
        .up_dn(up_dn), .d(d), .q(q9), .rco(rco9));

    ic74x163_counter_n #(.WIDTH(4), .MAX(15)) casc_lo (
        .clk(clk), .rst(rst_c), .load(1'b0), .enp(enp_c), .ent(1'b1),
        .up_dn(1'b1), .d(d_c), .q(q_lo), .rco(rco_lo));

    ic74x163_counter_n #(.WIDTH(4), .MAX(15)) casc_hi (
        .clk(clk), .rst(rst_c), .load(1'b0), .enp(enp_c), .ent(rco_lo),
        .up_dn(1'b1), .d(d_c), .q(q_hi), .rco(rco_hi));

    // ------------------------------------------------------------------
    // Behavioural reference model (plain integer arithmetic)
    // ------------------------------------------------------------------
    int m15 = 0, m9 = 0, mc = 0;
    bit mvalid = 1'b0, mcvalid = 1'b0;

    function automatic int model_next(input int m, input int max, input bit r,
                                      input bit ld, input int dv, input bit ep,
                                      input bit et, input bit up);
        if (r)               return 0;
        if (ld)              return dv;
        if (!(ep && et))     return m;
        if (up)              return (m > max) ? 0 : (m + 1) % (max + 1);
        return (m == 0) ? max : m - 1;
    endfunction

    function automatic int model_rco(input int m, input int max, input bit et,
                                     input bit up);
        if (!et) return 0;
        return up ? int'(m >= max) : int'(m == 0);
    endfunction

    always @(posedge clk) begin
        m15 = model_next(m15, 15, rst, load, int'(d), enp, ent, up_dn);
        m9  = model_next(m9,  9,  rst, load, int'(d), enp, ent, up_dn);
        if (rst) mvalid = 1'b1;
        mc = rst_c ? 0 : (enp_c ? (mc + 1) % 256 : mc);
        if (rst_c) mcvalid = 1'b1;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (mvalid) begin
            chk("m_q15",  {28'd0, q15}, m15);
            chk("m_rco15", {31'd0, rco15}, model_rco(m15, 15, ent, up_dn));
            chk("m_q9",   {28'd0, q9},  m9);
            chk("m_rco9", {31'd0, rco9}, model_rco(m9, 9, ent, up_dn));
        end
        if (mcvalid) begin
            chk("m_casc", {24'd0, q_hi, q_lo}, mc);
            chk("m_casc_rco_lo", {31'd0, rco_lo}, int'((mc % 16) == 15));
            chk("m_casc_rco_hi", {31'd0, rco_hi}, int'(mc == 255));
        end
    endtask

    // One clock edge, then compare on the falling edge; inputs are
    // changed by the caller only after the compare.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_in(input bit r, input bit ld, input logic [3:0] dv,
                          input bit ep, input bit et, input bit up);
        rst = r; load = ld; d = dv; enp = ep; ent = et; up_dn = up;
    endtask

    int exp_dn [4] = '{1, 0, 9, 8};

    initial begin
        // Reset, then up-count 17 edges
        set_in(1, 0, 4'd0, 0, 0, 1);
        tick();
        chk("rst_q15", {28'd0, q15}, 0);
        chk("rst_q9",  {28'd0, q9},  0);
        set_in(0, 0, 4'd0, 1, 1, 1);
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("up_q15", {28'd0, q15}, i % 16);
            chk("up_rco15", {31'd0, rco15}, int'((i % 16) == 15));
        end

        // Decade: count to 9, drop ent, then wrap
        set_in(1, 0, 4'd0, 0, 0, 1);
        tick();
        set_in(0, 0, 4'd0, 1, 1, 1);
        for (int i = 0; i < 9; i++) tick();
        chk("dec_q9_at9", {28'd0, q9}, 9);
        chk("dec_rco9_at9", {31'd0, rco9}, 1);
        ent = 1'b0;
        #1;
        chk("dec_rco9_ent0", {31'd0, rco9}, 0);
        ent = 1'b1;
        tick();
        chk("dec_wrap", {28'd0, q9}, 0);

        // Down count from 2
        set_in(0, 1, 4'd2, 0, 0, 0);
        tick();
        chk("dn_load", {28'd0, q9}, 2);
        set_in(0, 0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dn_q9", {28'd0, q9}, exp_dn[i]);
            chk("dn_rco9", {31'd0, rco9}, int'(exp_dn[i] == 0));
        end

        // Priority
        set_in(0, 1, 4'd5, 0, 0, 1);
        tick();
        chk("pri_load5", {28'd0, q9}, 5);
        set_in(1, 1, 4'd7, 1, 1, 1);
        tick();
        chk("pri_rst_wins", {28'd0, q9}, 0);
        set_in(0, 1, 4'd7, 1, 1, 1);
        tick();
        chk("pri_load_no_inc", {28'd0, q9}, 7);
        set_in(0, 0, 4'd0, 0, 1, 1);
        tick();
        chk("pri_enp0_hold", {28'd0, q9}, 7);
        set_in(0, 0, 4'd0, 1, 0, 1);
        tick();
        chk("pri_ent0_hold", {28'd0, q9}, 7);
        chk("pri_ent0_rco", {31'd0, rco9}, 0);

        // Out-of-range load on the decade counter
        set_in(0, 1, 4'd12, 1, 1, 1);
        tick();
        chk("oor_q", {28'd0, q9}, 12);
        chk("oor_rco_before", {31'd0, rco9}, 1);
        load = 1'b0;
        tick();
        chk("oor_up_wrap", {28'd0, q9}, 0);
        set_in(0, 1, 4'd12, 1, 1, 0);
        tick();
        set_in(0, 0, 4'd0, 1, 1, 0);
        tick();
        chk("oor_down", {28'd0, q9}, 11);

        // Direction change: rco follows up_dn immediately
        set_in(0, 1, 4'd0, 0, 1, 1);
        tick();
        chk("dir_rco_up_at0", {31'd0, rco9}, 0);
        up_dn = 1'b0;
        #1;
        chk("dir_rco_dn_at0", {31'd0, rco9}, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                   4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            tick();
        end

        // Cascade: 255 edges from reset, then wrap
        set_in(0, 0, 4'd0, 0, 0, 1);
        rst_c = 1'b1; enp_c = 1'b1;
        tick();
        chk("casc_rst", {24'd0, q_hi, q_lo}, 0);
        rst_c = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        chk("casc_ff", {24'd0, q_hi, q_lo}, 8'hFF);
        chk("casc_rco_hi_ff", {31'd0, rco_hi}, 1);
        tick();
        chk("casc_wrap", {24'd0, q_hi, q_lo}, 0);
        chk("casc_rco_hi_0", {31'd0, rco_hi}, 0);

        // Cascade under random enp
        for (int i = 0; i < 300; i++) begin
            enp_c = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
